// File: rtl/tdm_demux_1_4.sv
// Receive side of a 4:1 slot-multiplexed link: tracks slot position against a
// frame sync marker and publishes a, b, c, d together once a full frame lands.
module tdm_demux_1_4 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         sync,
    input  logic         err_clr,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic         s1,
    output logic         s0,
    output logic         frame_done,
    output logic         sync_err
);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t       state;
    logic [1:0]   slot;
    logic [W-1:0] sa, sb, sc;
    logic         err_set;

    assign s1 = slot[1];
    assign s0 = slot[0];

    // Early sync (sync off slot 0) or missing sync (no sync on slot 0) while locked.
    always_comb begin
        err_set = 1'b0;
        if (state == LOCK && din_valid)
            err_set = sync ? (slot != 2'd0) : (slot == 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            slot       <= 2'd0;
            sa         <= '0;
            sb         <= '0;
            sc         <= '0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            d          <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (err_set)      sync_err <= 1'b1;
            else if (err_clr) sync_err <= 1'b0;

            case (state)
                HUNT: begin
                    if (din_valid && sync) begin
                        sa    <= din;
                        slot  <= 2'd1;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (din_valid) begin
                        if (sync) begin
                            // Normal slot 0, or resync in place dropping the partial frame.
                            sa   <= din;
                            slot <= 2'd1;
                        end else begin
                            case (slot)
                                2'd0: state <= HUNT;
                                2'd1: begin
                                    sb   <= din;
                                    slot <= 2'd2;
                                end
                                2'd2: begin
                                    sc   <= din;
                                    slot <= 2'd3;
                                end
                                default: begin
                                    a          <= sa;
                                    b          <= sb;
                                    c          <= sc;
                                    d          <= din;
                                    frame_done <= 1'b1;
                                    slot       <= 2'd0;
                                end
                            endcase
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: doc/tdm_demux_1_4.md
# tdm_demux_1_4

Time-division 1:4 demultiplexer: the receive end of a 4:1 slot-multiplexed link whose slot order is a, b, c, d (select s1,s0 = 00, 01, 10, 11). It samples one slot per valid cycle from a single input lane, tracks slot position against a frame sync marker, and publishes all four channels together as one coherent frame. It also flags sync loss.

## Interface
Parameters:
- W, default 1: data width of each slot and channel.

Ports:
- clk  in  1  the only clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  W  slot data; sampled only when din_valid=1.
- din_valid  in  1  a slot is present on din this cycle.
- sync  in  1  marks slot 0 (a) of a frame; ignored unless din_valid=1.
- err_clr  in  1  clears sync_err.
- a, b, c, d  out  W  published channel values for slots 0..3; registered.
- s1, s0  out  1  index of the next expected slot; registered.
- frame_done  out  1  one-cycle pulse when a new complete frame is published on a..d.
- sync_err  out  1  sticky sync-error flag.

## Operation
- State machine with two states: HUNT and LOCK. Internal 2-bit slot counter {s1,s0}. Shadow registers sa, sb, sc hold slots 0..2 of the frame in progress.
- HUNT:
  - Cycles with din_valid=0 are ignored.
  - din_valid=1 with sync=0 is discarded.
  - din_valid=1 with sync=1: sa<=din, slot<=01, go to LOCK.
- LOCK, din_valid=0: no state change.
- LOCK, din_valid=1, sync=0, slot=01 or 10: write din to sb or sc; slot increments.
- LOCK, din_valid=1, sync=0, slot=11: publish the frame in one edge. a<=sa, b<=sb, c<=sc, d<=din. frame_done<=1, slot<=00, stay in LOCK.
- LOCK, din_valid=1, sync=0, slot=00 (missing sync): sync_err<=1, go to HUNT. Data is not captured.
- LOCK, din_valid=1, sync=1, slot=00: normal slot-0 capture. sa<=din, slot<=01.
- LOCK, din_valid=1, sync=1, slot≠00 (early sync): sync_err<=1. The partial frame is discarded with no publish. Resync in place: sa<=din, slot<=01, stay in LOCK.
- a..d change only on a publish. The previous frame stays visible until the next full frame completes.
- sync_err stays set until cleared:
  - err_clr=1 clears it on the next edge.
  - If a new error is detected in the same cycle as err_clr, sync_err stays 1 (set wins).
- Arithmetic: the slot counter wraps 11->00 only through a publish. There is no other wrap path.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately): state=HUNT, slot/s1,s0=00, sa=sb=sc=0, a=b=c=d=0, frame_done=0, sync_err=0. Deasserting reset is synchronous to clk; the first capture is at the first edge after rst_n=1.
- Latency: the slot-3 sample at edge k makes the new a..d and frame_done=1 visible after edge k. frame_done returns to 0 after edge k+1.
- Minimum frame time is 4 cycles. Back-to-back frames give a frame_done pulse every 4 cycles, with no bubble required between frames.
- din_valid gaps of any length inside a frame are allowed. The slot position is held across gaps.
- s1,s0 always show the slot that the next valid sample will fill. It reads 00 in HUNT.
- Reset mid-frame discards the partial frame and clears the published outputs.

## Test plan
- Clean frame, W=1: reset, then valid slots 0,1,1,1 with sync on the first -> after the 4th edge a=0, b=1, c=1, d=1, frame_done high exactly 1 cycle, s1s0=00.
- Gapped frame, W=4: slots 0x3, 0x5, 0xA, 0xC with din_valid low 2 cycles between each -> a..d hold the old values (0) until the 0xC edge, then read 3/5/A/C together; one frame_done pulse.
- Early sync: after 2 slots, assert sync with din=0x7 -> sync_err=1, no frame_done, s1s0=01. Completing 3 more slots publishes a=0x7.
- Missing sync: after a published frame, din_valid=1 with sync=0 -> sync_err=1, state HUNT, a..d unchanged. Samples are ignored until the next sync.
- err_clr: a pulse with no error clears sync_err the next cycle. err_clr in the same cycle as an early sync leaves sync_err=1.
- Reset mid-frame: pull rst_n low asynchronously between edges after 3 slots -> a..d, frame_done, sync_err, and s1s0 read 0 immediately. No publish occurs after release until a full new frame arrives.
